// File: rtl/ball_ctrl.sv
// Ball motion engine: holds the ball on the platform until shot, then steps it one
// pixel at a time, handing each step to the collision block through a req/ack handshake.
module ball_ctrl #(
  parameter int PIXELX_BITS = 10,
  parameter int PIXELY_BITS = 9,
  parameter int SIZE_BITS   = 4,
  parameter int STEP_BITS   = 3,
  parameter int DIR_BITS    = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_game_start,
  input  logic                   i_cal_frame,
  input  logic                   i_shoot_ball,
  output logic [PIXELX_BITS-1:0] o_ballX,
  output logic [PIXELY_BITS-1:0] o_ballY,
  output logic [SIZE_BITS-1:0]   o_ball_size,
  output logic [1:0]             o_ball_speedX,
  output logic [1:0]             o_ball_speedY,
  output logic [2:0]             o_damage,
  input  logic                   i_ball_collision,
  input  logic [DIR_BITS-1:0]    i_direc_var,
  output logic                   o_ball_ack,
  output logic                   o_ball_frame_term,
  input  logic                   i_ball_req,
  input  logic                   i_grab,
  input  logic [PIXELX_BITS-1:0] i_platX,
  input  logic [PIXELY_BITS-1:0] i_platY,
  input  logic [STEP_BITS-1:0]   i_ball_speedstep,
  input  logic [SIZE_BITS-1:0]   i_ball_size,
  output logic [2:0]             o_state,
  output logic [2:0]             o_counter,
  output logic                   o_handshake
);
  localparam logic [2:0] S_HOLD = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_WREQ = 3'd2;
  localparam logic [2:0] S_WCOL = 3'd3;
  localparam logic [2:0] S_MOVE = 3'd4;
  localparam logic [2:0] S_TERM = 3'd5;

  logic [2:0]             state;
  logic [STEP_BITS-1:0]   counter;
  logic                   held;
  logic                   wc_second;
  logic [PIXELX_BITS-1:0] ball_x;
  logic [PIXELY_BITS-1:0] ball_y;
  logic [SIZE_BITS-1:0]   size;
  logic [1:0]             sx, sy;
  logic                   ack, term;

  // Speed/mode after applying this cycle's collision code (if any)
  logic [1:0] col_sx, col_sy;
  logic       col_hold;

  always_comb begin
    col_sx   = sx;
    col_sy   = sy;
    col_hold = 1'b0;
    if (i_ball_collision) begin
      case (i_direc_var)
        DIR_BITS'(1): col_sx = 2'b00 - sx;
        DIR_BITS'(2): col_sy = 2'b00 - sy;
        DIR_BITS'(3): begin col_sx = 2'b00 - sx; col_sy = 2'b00 - sy; end
        DIR_BITS'(4): begin col_sx = 2'b11; col_sy = 2'b11; end
        DIR_BITS'(5): begin col_sx = 2'b00; col_sy = 2'b11; end
        DIR_BITS'(6): begin col_sx = 2'b01; col_sy = 2'b11; end
        DIR_BITS'(18): begin
          if (i_grab) begin
            col_sx = 2'b00; col_sy = 2'b00; col_hold = 1'b1;
          end else begin
            col_sy = 2'b00 - sy;
          end
        end
        DIR_BITS'(19): begin col_sx = 2'b00; col_sy = 2'b00; col_hold = 1'b1; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_HOLD;
      counter   <= '0;
      held      <= 1'b1;
      wc_second <= 1'b0;
      ball_x    <= PIXELX_BITS'(320);
      ball_y    <= PIXELY_BITS'(400);
      size      <= SIZE_BITS'(4);
      sx        <= 2'b00;
      sy        <= 2'b00;
      ack       <= 1'b0;
      term      <= 1'b0;
    end else begin
      ack  <= 1'b0;
      term <= 1'b0;
      if (i_game_start) begin
        state   <= S_HOLD;
        sx      <= 2'b00;
        sy      <= 2'b00;
        counter <= '0;
        held    <= 1'b1;
      end else begin
        case (state)
          S_HOLD: if (i_cal_frame) begin
            size   <= i_ball_size;
            ball_x <= i_platX;
            ball_y <= i_platY - PIXELY_BITS'(i_ball_size);
            if (i_shoot_ball) begin
              sx      <= 2'b01;
              sy      <= 2'b11;
              counter <= i_ball_speedstep;
              held    <= 1'b0;
            end else begin
              sx      <= 2'b00;
              sy      <= 2'b00;
              counter <= '0;
            end
            state <= S_WREQ;
          end
          S_IDLE: if (i_cal_frame) begin
            size    <= i_ball_size;
            counter <= i_ball_speedstep;
            state   <= S_WREQ;
          end
          S_WREQ: if (i_ball_req) begin
            ack       <= 1'b1;
            wc_second <= 1'b0;
            state     <= S_WCOL;
          end
          S_WCOL: begin
            sx        <= col_sx;
            sy        <= col_sy;
            wc_second <= 1'b1;
            if (col_hold) begin
              held    <= 1'b1;
              counter <= '0;
            end
            // A grab/loss on the last collision cycle must still skip the move
            if (wc_second) begin
              if (col_hold || counter == '0) begin
                state <= S_TERM;
                term  <= 1'b1;
              end else begin
                state <= S_MOVE;
              end
            end
          end
          S_MOVE: begin
            ball_x  <= ball_x + {{(PIXELX_BITS-2){sx[1]}}, sx};
            ball_y  <= ball_y + {{(PIXELY_BITS-2){sy[1]}}, sy};
            counter <= counter - 1'b1;
            state   <= S_WREQ;
          end
          S_TERM:  state <= held ? S_HOLD : S_IDLE;
          default: state <= S_HOLD;
        endcase
      end
    end
  end

  assign o_ballX           = ball_x;
  assign o_ballY           = ball_y;
  assign o_ball_size       = size;
  assign o_ball_speedX     = sx;
  assign o_ball_speedY     = sy;
  assign o_damage          = 3'd1;
  assign o_ball_ack        = ack;
  assign o_ball_frame_term = term;
  assign o_state           = state;
  assign o_counter         = 3'(counter);
  assign o_handshake       = (state == S_WREQ);
endmodule

// File: tb/tb_ball_ctrl.sv
// Bench for ball_ctrl: directed frame sequences, a direction-code vector table and
// randomized frames checked against a per-step reference model of the ball.
module tb_ball_ctrl;
  logic       clk = 0, rst_n = 0;
  logic       game_start = 0, cal_frame = 0, shoot_ball = 0;
  logic [9:0] ballX;
  logic [8:0] ballY;
  logic [3:0] ball_size;
  logic [1:0] speedX, speedY;
  logic [2:0] damage;
  logic       ball_collision = 0;
  logic [4:0] direc_var = 0;
  logic       ball_ack, frame_term;
  logic       ball_req = 1, grab = 0;
  logic [9:0] platX = 10'd320;
  logic [8:0] platY = 9'd440;
  logic [2:0] speedstep = 0;
  logic [3:0] bsize = 4'd4;
  logic [2:0] state, counter;
  logic       handshake;

  ball_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_game_start(game_start), .i_cal_frame(cal_frame),
    .i_shoot_ball(shoot_ball), .o_ballX(ballX), .o_ballY(ballY), .o_ball_size(ball_size),
    .o_ball_speedX(speedX), .o_ball_speedY(speedY), .o_damage(damage),
    .i_ball_collision(ball_collision), .i_direc_var(direc_var), .o_ball_ack(ball_ack),
    .o_ball_frame_term(frame_term), .i_ball_req(ball_req), .i_grab(grab),
    .i_platX(platX), .i_platY(platY), .i_ball_speedstep(speedstep), .i_ball_size(bsize),
    .o_state(state), .o_counter(counter), .o_handshake(handshake)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  // Reference model: position, speed as -1/0/+1, held mode, steps left
  int mx, my, msx, msy, mrem, msize;
  bit mheld;
  // Snapshot taken at frame_term
  int t_x, t_y, t_sx, t_sy, t_acks, t_st;

  typedef struct {
    int code; bit grab; int ex; int ey; int esx; int esy; int acks; int st;
  } vec_t;
  vec_t vt[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int enc(input int s);
    return (s == 0) ? 0 : ((s > 0) ? 1 : 3);
  endfunction

  task automatic apply_code(input int code);
    case (code)
      1: msx = -msx;
      2: msy = -msy;
      3: begin msx = -msx; msy = -msy; end
      4: begin msx = -1; msy = -1; end
      5: begin msx = 0;  msy = -1; end
      6: begin msx = 1;  msy = -1; end
      18: if (grab) begin mheld = 1; msx = 0; msy = 0; mrem = 0; end else msy = -msy;
      19: begin mheld = 1; msx = 0; msy = 0; mrem = 0; end
      default: ;
    endcase
  endtask

  task automatic do_gs();
    @(negedge clk); game_start = 1;
    @(negedge clk); game_start = 0;
    mheld = 1; msx = 0; msy = 0; mrem = 0;
  endtask

  task automatic model_cal(input bit shoot, input int step);
    msize = bsize;
    if (mheld) begin
      mx = platX; my = (int'(platY) - int'(bsize)) & 511;
      if (shoot) begin msx = 1; msy = -1; mrem = step; mheld = 0; end
      else begin msx = 0; msy = 0; mrem = 0; end
    end else mrem = step;
  endtask

  // One frame: cal_frame pulse, then service acks until frame_term
  task automatic run_frame(input bit shoot, input int step, input int fcode,
                           input int fidx, input bit rnd);
    int code, dly, pcode;
    bit pend, exp_term, done;
    int codes[10] = '{0, 1, 2, 3, 4, 5, 6, 18, 19, 9};
    model_cal(shoot, step);
    @(negedge clk); cal_frame = 1; shoot_ball = shoot; speedstep = 3'(step);
    @(negedge clk); cal_frame = 0; shoot_ball = 0;
    t_acks = 0; exp_term = 0; done = 0; pend = 0; pcode = 0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      ball_collision = 0;
      if (pend) begin ball_collision = 1; direc_var = 5'(pcode); pend = 0; end
      if (rnd) ball_req = ($urandom_range(0, 3) != 0);
      if (ball_ack) begin
        t_acks++;
        chk("extra_ack", int'(exp_term), 0);
        chk("ack_x", int'(ballX), mx);
        chk("ack_y", int'(ballY), my);
        chk("ack_sx", int'(speedX), enc(msx));
        chk("ack_sy", int'(speedY), enc(msy));
        chk("ack_counter", int'(counter), mrem);
        code = -1; dly = 0;
        if (rnd) begin
          if ($urandom_range(0, 2) == 0) begin
            code = codes[$urandom_range(0, 9)];
            dly  = $urandom_range(0, 1);
          end
        end else if (t_acks - 1 == fidx) code = fcode;
        if (code >= 0) begin
          apply_code(code);
          if (dly == 0) begin ball_collision = 1; direc_var = 5'(code); end
          else begin pend = 1; pcode = code; end
        end
        if (mheld || mrem == 0) exp_term = 1;
        else begin
          mx = (mx + msx) & 1023; my = (my + msy) & 511; mrem--;
        end
      end
      if (frame_term) begin
        chk("term_expected", int'(exp_term), 1);
        t_x = ballX; t_y = ballY; t_sx = speedX; t_sy = speedY;
        chk("term_x", t_x, mx);
        chk("term_y", t_y, my);
        chk("term_sx", t_sx, enc(msx));
        chk("term_sy", t_sy, enc(msy));
        chk("term_size", int'(ball_size), msize);
        chk("term_state", int'(state), 5);
        done = 1;
      end
      @(negedge clk);
    end
    ball_collision = 0;
    ball_req = 1;
    if (!done) chk("frame_timeout", 0, 1);
    else begin
      t_st = state;
      chk("post_term_state", t_st, mheld ? 0 : 1);
    end
  endtask

  initial begin
    int nack, nterm;
    bit found;
    vt[0]  = '{0,  0, 321, 435, 1, 3, 2, 1};
    vt[1]  = '{1,  0, 319, 435, 3, 3, 2, 1};
    vt[2]  = '{2,  0, 321, 437, 1, 1, 2, 1};
    vt[3]  = '{3,  0, 319, 437, 3, 1, 2, 1};
    vt[4]  = '{4,  0, 319, 435, 3, 3, 2, 1};
    vt[5]  = '{5,  0, 320, 435, 0, 3, 2, 1};
    vt[6]  = '{6,  0, 321, 435, 1, 3, 2, 1};
    vt[7]  = '{18, 1, 320, 436, 0, 0, 1, 0};
    vt[8]  = '{18, 0, 321, 437, 1, 1, 2, 1};
    vt[9]  = '{19, 0, 320, 436, 0, 0, 1, 0};
    vt[10] = '{7,  0, 321, 435, 1, 3, 2, 1};
    vt[11] = '{31, 1, 321, 435, 1, 3, 2, 1};

    mx = 320; my = 400; msx = 0; msy = 0; mrem = 0; mheld = 1; msize = 4;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_x", int'(ballX), 320);
    chk("rst_y", int'(ballY), 400);
    chk("rst_size", int'(ball_size), 4);
    chk("rst_speed", int'({speedX, speedY}), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_counter", int'(counter), 0);
    chk("rst_ack_term", int'({ball_ack, frame_term}), 0);
    chk("damage", int'(damage), 1);

    // Held frame: ball sits on the platform, single handshake
    run_frame(0, 0, -1, 0, 0);
    chk("held_acks", t_acks, 1);
    chk("held_pos", t_x * 1000 + t_y, 320436);
    chk("held_state", t_st, 0);

    // Shoot with 3 steps
    run_frame(1, 3, -1, 0, 0);
    chk("shoot_acks", t_acks, 4);
    chk("shoot_pos", t_x * 1000 + t_y, 323433);
    chk("shoot_speed", t_sx * 4 + t_sy, 7);
    chk("shoot_state", t_st, 1);

    // Bounce off the top during step 1: Y turns downward
    run_frame(0, 3, 2, 1, 0);
    chk("bounce_pos", t_x * 1000 + t_y, 326434);
    chk("bounce_sy", t_sy, 1);

    // Grab mid-frame skips the remaining steps
    grab = 1;
    run_frame(0, 3, 18, 1, 0);
    chk("grab_acks", t_acks, 2);
    chk("grab_pos", t_x * 1000 + t_y, 327435);
    chk("grab_state", t_st, 0);
    platX = 10'd100; platY = 9'd200;
    run_frame(0, 5, -1, 0, 0);
    chk("track_pos", t_x * 1000 + t_y, 100196);
    chk("track_acks", t_acks, 1);
    grab = 0;

    // game_start during WAIT_COL aborts the frame
    model_cal(1, 3);
    @(negedge clk); cal_frame = 1; shoot_ball = 1; speedstep = 3'd3;
    @(negedge clk); cal_frame = 0; shoot_ball = 0;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (ball_ack) found = 1;
      else @(negedge clk);
    end
    chk("gs_ack_seen", int'(found), 1);
    chk("gs_in_wcol", int'(state), 3);
    game_start = 1;
    @(negedge clk); game_start = 0;
    mheld = 1; msx = 0; msy = 0; mrem = 0;
    chk("gs_state", int'(state), 0);
    chk("gs_speed", int'({speedX, speedY}), 0);
    chk("gs_counter", int'(counter), 0);
    nterm = 0;
    for (int i = 0; i < 20; i++) begin
      if (frame_term || state != 3'd0) nterm++;
      @(negedge clk);
    end
    chk("gs_no_term", nterm, 0);

    // Request held low: ball waits in WAIT_REQ with no ack
    ball_req = 0;
    model_cal(0, 0);
    @(negedge clk); cal_frame = 1;
    @(negedge clk); cal_frame = 0;
    nack = 0;
    for (int i = 0; i < 10; i++) begin
      nack += int'(ball_ack);
      @(negedge clk);
    end
    chk("reqlow_acks", nack, 0);
    chk("reqlow_state", int'(state), 2);
    chk("reqlow_handshake", int'(handshake), 1);
    ball_req = 1;
    @(negedge clk);
    chk("req_ack_next", int'(ball_ack), 1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (frame_term) found = 1;
      @(negedge clk);
    end
    chk("reqlow_term", int'(found), 1);
    chk("reqlow_pos", int'(ballX) * 1000 + int'(ballY), mx * 1000 + my);

    // Direction-code table, one step per frame from a fresh shot
    platX = 10'd320; platY = 9'd440; bsize = 4'd4;
    foreach (vt[k]) begin
      do_gs();
      grab = vt[k].grab;
      run_frame(1, 1, vt[k].code, 0, 0);
      chk($sformatf("vec%0d_pos", k), t_x * 1000 + t_y, vt[k].ex * 1000 + vt[k].ey);
      chk($sformatf("vec%0d_speed", k), t_sx * 4 + t_sy, vt[k].esx * 4 + vt[k].esy);
      chk($sformatf("vec%0d_acks", k), t_acks, vt[k].acks);
      chk($sformatf("vec%0d_state", k), t_st, vt[k].st);
    end
    grab = 0;

    // Randomized frames against the model
    for (int f = 0; f < 60; f++) begin
      if (mheld) begin
        platX = 10'($urandom_range(0, 1023));
        platY = 9'($urandom_range(0, 511));
      end
      bsize = 4'($urandom_range(0, 15));
      grab  = 1'($urandom_range(0, 1));
      run_frame(mheld ? 1'($urandom_range(0, 3) != 0) : 1'b0,
                $urandom_range(0, 7), -1, 0, 1);
      if ($urandom_range(0, 9) == 0) do_gs();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ball_ctrl.md
# ball_ctrl

Per-frame ball motion engine of the brick-breaker game logic. Holds the ball on the platform until a shoot command, then advances it one pixel per step, `i_ball_speedstep` steps per frame. Before each step it hands its position and speed to the collision block through a req/ack handshake, then applies the returned direction change. It reports end-of-frame to the collision block.

## Interface
Parameters:
- PIXELX_BITS, 10, X coordinate width
- PIXELY_BITS, 9, Y coordinate width
- SIZE_BITS, 4, ball size width
- STEP_BITS, 3, steps-per-frame width
- DIR_BITS, 5, direction-code width

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- i_game_start  in  1  return ball to platform hold
- i_cal_frame  in  1  one-cycle frame-start pulse
- i_shoot_ball  in  1  release ball; sampled only with i_cal_frame
- o_ballX  out  PIXELX_BITS  ball X
- o_ballY  out  PIXELY_BITS  ball Y
- o_ball_size  out  SIZE_BITS  registered ball size
- o_ball_speedX, o_ball_speedY  out  2 each  00=0, 01=+1, 11=-1
- o_damage  out  3  constant 3'd1
- i_ball_collision  in  1  one-cycle pulse, apply i_direc_var
- i_direc_var  in  DIR_BITS  direction code
- o_ball_ack  out  1  one-cycle handshake ack
- o_ball_frame_term  out  1  one-cycle end-of-frame pulse
- i_ball_req  in  1  level request from collision
- i_grab  in  1  platform grab mode enabled
- i_platX, i_platY  in  PIXELX/PIXELY_BITS  platform centre/top
- i_ball_speedstep  in  STEP_BITS  steps per frame
- i_ball_size  in  SIZE_BITS  size from platform
- o_state  out  3  debug state
- o_counter  out  3  steps remaining
- o_handshake  out  1  high while in WAIT_REQ

## Operation
- States (o_state code):
  - HOLD=0: ball on platform.
  - IDLE=1: free, waiting.
  - WAIT_REQ=2
  - WAIT_COL=3
  - MOVE=4
  - TERM=5
- HOLD + i_cal_frame:
  - Latch o_ball_size=i_ball_size.
  - Set ballX=i_platX, ballY=i_platY-i_ball_size.
  - If i_shoot_ball: speed=(+1,-1), counter=i_ball_speedstep, mode becomes free. Otherwise speed=(0,0), counter=0.
  - Go to WAIT_REQ.
- IDLE + i_cal_frame: latch size, counter=i_ball_speedstep, go to WAIT_REQ.
- WAIT_REQ: when i_ball_req=1, pulse o_ball_ack for one cycle and go to WAIT_COL.
- WAIT_COL: stay exactly 2 cycles. Any i_ball_collision pulse in these cycles updates speed/mode from i_direc_var. Then:
  - counter==0: go to TERM.
  - otherwise: go to MOVE.
- MOVE (1 cycle): X+=speedX, Y+=speedY (modulo 2^width, no clamping); counter-=1; go to WAIT_REQ.
- TERM (1 cycle): pulse o_ball_frame_term; go to HOLD if held, else IDLE.
- Direction codes (speed rules: 00 unchanged by negation; 10 never produced):
  - 0: none.
  - 1: negate X.
  - 2: negate Y.
  - 3: negate both.
  - 4/5/6: set speed (-1,-1)/(0,-1)/(+1,-1).
  - 18: if i_grab, enter held mode with speed (0,0) and counter=0. Otherwise same as 2.
  - 19: ball lost; enter held mode, speed (0,0), counter=0.
  - Others: ignored.
- i_cal_frame outside HOLD/IDLE is ignored.
- i_game_start (any state) forces HOLD next cycle: speed (0,0), counter=0, no ack/term pulses.

## Timing
- Reset values:
  - ballX=320, ballY=400, size=4, speed=(0,0)
  - state HOLD, counter=0
  - ack=0, frame_term=0, o_damage=1
- Outputs are registered. o_ball_ack rises the cycle after i_ball_req is seen high in WAIT_REQ.
- Position and speed are stable from WAIT_REQ entry until MOVE, so collision may sample them on ack.
- Frame latency for N steps: 1 + N*(ack wait + 1 ack + 2 WAIT_COL + 1 MOVE) + final handshake + TERM. With req already high, latency ≤ 5N+6 cycles. This must fit in the 300-cycle frame period for N≤7.
- One handshake per step plus one final handshake, so a frame has N+1 acks. Held frames have exactly 1 ack.

## Test plan
- Reset, req tied high, cal_frame every 300 cycles, platX=320, platY=440, size=4 -> ball at (320,436), speed 0, one ack and one frame_term per frame, o_state returns to 0.
- Shoot with cal_frame, speedstep=3 -> speed (01,11), 4 acks, position (323,433) at frame_term, state then 1.
- Free ball, i_ball_collision with direc_var=2 during WAIT_COL of step 1 -> speedY becomes 01, remaining steps move Y down.
- direc_var=18 with i_grab=1 mid-frame -> remaining steps skipped, frame_term pulses, next frame tracks platform.
- i_game_start asserted in WAIT_COL -> HOLD next cycle, speed 0, no frame_term that frame.
- req held low -> ball stays in WAIT_REQ with o_handshake=1, no ack; later req=1 -> ack 1 cycle later.
